// File: rtl/div_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl_pkg
// Purpose  : Shared types and constants for the divider issue controller.
//            state_t     - controller states
//            OP_UNSIGNED - op bit selecting the unsigned divider IP
//            OP_MOD      - op bit selecting remainder instead of quotient
// Revision : 1.0 - initial release
// ============================================================================
package div_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int OP_UNSIGNED = 1;
  localparam int OP_MOD      = 0;

endpackage
`default_nettype wire

// File: rtl/div_zero_fixup.sv
`default_nettype none
// ============================================================================
// Module   : div_zero_fixup
// Purpose  : Combinational zero-divisor detect and architectural fixup value.
//            Only instantiated when DIV_ZERO_FIXUP_EN is defined.
// Ports    : src1      in  W - dividend
//            src2      in  W - divisor
//            is_mod    in  1 - operation is a remainder
//            is_zero   out 1 - divisor is zero
//            fix_value out W - all-ones for a quotient, dividend for a remainder
// Revision : 1.0 - initial release
// ============================================================================
module div_zero_fixup #(
  parameter int W = 32
) (
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  input  logic         is_mod,
  output logic         is_zero,
  output logic [W-1:0] fix_value
);

  assign is_zero   = (src2 == '0);
  assign fix_value = is_mod ? src1 : '1;

endmodule
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Sequences one div/mod operation at a time onto the signed or
//            unsigned pipelined divider IP, holds the result for EXE until it
//            advances, and drains in-flight IP results after a flush so a
//            stale result is never returned to a later instruction.
// Config   : DIV_ZERO_FIXUP_EN - zero divisors bypass the IP and complete the
//            next cycle with all-ones (div) or the dividend (mod).
// Ports    : clk, reset (sync, active-high), flush
//            op_valid/op/src1/src2/es_advance - EXE request side
//            ready_go/result                  - EXE response side
//            div_src1/div_src2                - shared IP operand tdata
//            sdiv_* / udiv_*                  - signed / unsigned IP handshake
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           op_valid,
  input  logic [1:0]     op,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  input  logic           es_advance,
  output logic           ready_go,
  output logic [W-1:0]   result,
  output logic [W-1:0]   div_src1,
  output logic [W-1:0]   div_src2,
  output logic           sdiv_tvalid,
  input  logic           sdiv_tready,
  input  logic           sdiv_dout_valid,
  input  logic [2*W-1:0] sdiv_dout,
  output logic           udiv_tvalid,
  input  logic           udiv_tready,
  input  logic           udiv_dout_valid,
  input  logic [2*W-1:0] udiv_dout
);

  state_t         state, state_nx;
  logic [1:0]     op_r, op_nx;
  logic [W-1:0]   result_r, result_nx;
  // A flush seen in ISSUE before the IP accepted the operands; tvalid must
  // stay up, so the cancel is remembered and applied on acceptance.
  logic           cancel_r, cancel_nx;

  logic           sel_uns;
  logic           sel_tready;
  logic           sel_dout_valid;
  logic [2*W-1:0] sel_dout;
  logic [W-1:0]   sel_half;
  logic           zero_hit;
  logic [W-1:0]   zero_value;

  assign sel_uns        = op_r[OP_UNSIGNED];
  assign sel_tready     = sel_uns ? udiv_tready     : sdiv_tready;
  assign sel_dout_valid = sel_uns ? udiv_dout_valid : sdiv_dout_valid;
  assign sel_dout       = sel_uns ? udiv_dout       : sdiv_dout;
  // IP packs quotient in the upper half, remainder in the lower half.
  assign sel_half       = op_r[OP_MOD] ? sel_dout[W-1:0] : sel_dout[2*W-1:W];

`ifdef DIV_ZERO_FIXUP_EN
  div_zero_fixup #(
    .W(W)
  ) u_div_zero_fixup (
    .src1      (src1),
    .src2      (src2),
    .is_mod    (op[OP_MOD]),
    .is_zero   (zero_hit),
    .fix_value (zero_value)
  );
`else
  assign zero_hit   = 1'b0;
  assign zero_value = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_r     <= '0;
      result_r <= '0;
      cancel_r <= 1'b0;
    end else begin
      state    <= state_nx;
      op_r     <= op_nx;
      result_r <= result_nx;
      cancel_r <= cancel_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    op_nx     = op_r;
    result_nx = result_r;
    cancel_nx = cancel_r;
    case (state)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          op_nx     = op;
          cancel_nx = 1'b0;
          if (zero_hit) begin
            result_nx = zero_value;
            state_nx  = ST_DONE;
          end else begin
            state_nx  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (sel_tready) begin
          state_nx = (cancel_r || flush) ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          cancel_nx = 1'b1;
        end
      end
      ST_WAIT: begin
        if (sel_dout_valid) begin
          if (flush) begin
            state_nx = ST_IDLE;
          end else begin
            result_nx = sel_half;
            state_nx  = ST_DONE;
          end
        end else if (flush) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (es_advance || flush) begin
          state_nx = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (sel_dout_valid) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operands are not latched: EXE holds src1/src2 until es_advance.
  assign div_src1    = src1;
  assign div_src2    = src2;
  assign sdiv_tvalid = (state == ST_ISSUE) && !sel_uns;
  assign udiv_tvalid = (state == ST_ISSUE) &&  sel_uns;
  assign ready_go    = (state == ST_DONE);
  assign result      = ready_go ? result_r : '0;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Purpose  : Self-checking bench for div_issue_ctrl. Two latency-programmable
//            divider IP stand-ins, a driver emulating EXE, and a monitor that
//            pops expected results from a scoreboard queue on each handoff.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic           op_valid = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   src1 = '0;
  logic [W-1:0]   src2 = '0;
  logic           es_advance = 1'b0;
  logic           ready_go;
  logic [W-1:0]   result;
  logic [W-1:0]   div_src1;
  logic [W-1:0]   div_src2;
  logic           sdiv_tvalid;
  logic           sdiv_tready = 1'b0;
  logic           sdiv_dout_valid = 1'b0;
  logic [2*W-1:0] sdiv_dout = '0;
  logic           udiv_tvalid;
  logic           udiv_tready = 1'b0;
  logic           udiv_dout_valid = 1'b0;
  logic [2*W-1:0] udiv_dout = '0;

  div_issue_ctrl #(.W(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .op_valid        (op_valid),
    .op              (op),
    .src1            (src1),
    .src2            (src2),
    .es_advance      (es_advance),
    .ready_go        (ready_go),
    .result          (result),
    .div_src1        (div_src1),
    .div_src2        (div_src2),
    .sdiv_tvalid     (sdiv_tvalid),
    .sdiv_tready     (sdiv_tready),
    .sdiv_dout_valid (sdiv_dout_valid),
    .sdiv_dout       (sdiv_dout),
    .udiv_tvalid     (udiv_tvalid),
    .udiv_tready     (udiv_tready),
    .udiv_dout_valid (udiv_dout_valid),
    .udiv_dout       (udiv_dout)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned lat_s = 4;
  int unsigned lat_u = 4;
  int          tready_mode = 1;   // 0 random, 1 high, 2 low
  bit          garbage_en = 1'b0;
  bit          cur_uns = 1'b0;
  int          s_tv_cnt = 0;
  int          u_tv_cnt = 0;

  typedef struct {
    int unsigned    due;
    logic [2*W-1:0] val;
  } pend_t;
  pend_t        s_pend[$];
  pend_t        u_pend[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Architectural meaning of the four ops (C-style truncating division).
  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) return o[0] ? a : '1;
    if (o[1]) return o[0] ? (a % b) : (a / b);
    return o[0] ? W'(sa % sb) : W'(sa / sb);
  endfunction

  // IP stand-in: computes in 64-bit and packs {quotient, remainder}.
  function automatic logic [2*W-1:0] ip_calc(input bit uns, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint na, nb, q, r;
    if (b == '0) return {{W{1'b1}}, a};
    if (uns) begin
      na = longint'({32'h0, a});
      nb = longint'({32'h0, b});
    end else begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end
    q = na / nb;
    r = na - q * nb;
    return {q[W-1:0], r[W-1:0]};
  endfunction

  // Divider IP models: accept on tvalid&tready, respond L cycles later.
  initial begin
    forever begin
      @(posedge clk);
      if (sdiv_tvalid) s_tv_cnt++;
      if (udiv_tvalid) u_tv_cnt++;
      if (sdiv_tvalid && sdiv_tready)
        s_pend.push_back('{due: cyc + lat_s, val: ip_calc(1'b0, div_src1, div_src2)});
      if (udiv_tvalid && udiv_tready)
        u_pend.push_back('{due: cyc + lat_u, val: ip_calc(1'b1, div_src1, div_src2)});
      cyc++;
      @(negedge clk);
      #1;
      sdiv_dout_valid = 1'b0;
      udiv_dout_valid = 1'b0;
      if (s_pend.size() > 0 && s_pend[0].due == cyc) begin
        sdiv_dout_valid = 1'b1;
        sdiv_dout       = s_pend.pop_front().val;
      end else if (garbage_en && cur_uns && s_pend.size() == 0 && $urandom_range(0, 3) == 0) begin
        sdiv_dout_valid = 1'b1;
        sdiv_dout       = {$urandom, $urandom};
      end
      if (u_pend.size() > 0 && u_pend[0].due == cyc) begin
        udiv_dout_valid = 1'b1;
        udiv_dout       = u_pend.pop_front().val;
      end else if (garbage_en && !cur_uns && u_pend.size() == 0 && $urandom_range(0, 3) == 0) begin
        udiv_dout_valid = 1'b1;
        udiv_dout       = {$urandom, $urandom};
      end
      case (tready_mode)
        1:       begin sdiv_tready = 1'b1; udiv_tready = 1'b1; end
        2:       begin sdiv_tready = 1'b0; udiv_tready = 1'b0; end
        default: begin sdiv_tready = 1'($urandom_range(0, 1)); udiv_tready = 1'($urandom_range(0, 1)); end
      endcase
    end
  end

  // Monitor: every handoff consumes one scoreboard entry; ready_go with
  // nothing outstanding means a stale or phantom result.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && ready_go) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ready_go_phantom: got ready_go=1 result=0x%08h, required no pending op", result);
        end else if (es_advance) begin
          e = exp_q.pop_front();
          check("scoreboard_result", result, e);
        end
      end
    end
  end

  // EXE emulation for one instruction. flush_at>0 kills it at that cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_at, input int hold,
                        output int lat_seen, output logic [W-1:0] res);
    int  i;
    bit  done;
    int  h;
    op_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    cur_uns  = o[1];
    exp_q.push_back(ref_result(o, a, b));
    lat_seen = -1;
    res      = '0;
    i        = 0;
    h        = hold;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      i++;
      if (flush_at > 0 && i == flush_at) begin
        flush    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        void'(exp_q.pop_back());
        done = 1'b1;
      end else if (ready_go) begin
        if (lat_seen < 0) lat_seen = i;
        if (h > 0) begin
          h--;
        end else begin
          res        = result;
          es_advance = 1'b1;
          @(negedge clk);
          es_advance = 1'b0;
          op_valid   = 1'b0;
          done       = 1'b1;
        end
      end else if (i > 300) begin
        checks++;
        errors++;
        $display("FAIL op_timeout: got no ready_go in %0d cycles, required completion", i);
        exp_q.delete();
        op_valid = 1'b0;
        done     = 1'b1;
      end
    end
  endtask

  // Watch ready_go for n cycles; one check, fails if it ever rises.
  task automatic watch_idle(input string name, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ready_go) seen++;
    end
    check(name, W'(seen), '0);
  endtask

  initial begin
    int           lat;
    logic [W-1:0] res;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    check("reset_ready_go", W'(ready_go), '0);
    check("reset_result", result, '0);
    check("reset_sdiv_tvalid", W'(sdiv_tvalid), '0);
    check("reset_udiv_tvalid", W'(udiv_tvalid), '0);
    reset = 1'b0;
    @(negedge clk);

    // div.w -7/2, L=4, tready=1
    tready_mode = 1; lat_s = 4; s_tv_cnt = 0;
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 2, lat, res);
    check("t1_result", res, 32'hFFFF_FFFD);
    check("t1_latency", W'(lat), 32'd6);
    check("t1_sdiv_tvalid_cycles", W'(s_tv_cnt), 32'd1);

    // mod.wu 17/5 with tready low for 3 ISSUE cycles
    s_tv_cnt = 0; u_tv_cnt = 0; lat_u = 4; tready_mode = 2;
    fork
      run_op(2'b11, 32'd17, 32'd5, 0, 0, lat, res);
      begin repeat (4) @(negedge clk); tready_mode = 1; end
    join
    check("t2_result", res, 32'd2);
    check("t2_udiv_tvalid_cycles", W'(u_tv_cnt), 32'd4);
    check("t2_sdiv_tvalid_cycles", W'(s_tv_cnt), 32'd0);

    // flush two cycles into WAIT, next op follows immediately
    s_tv_cnt = 0; lat_s = 4;
    run_op(2'b00, 32'd100, 32'd7, 4, 0, lat, res);
    run_op(2'b00, 32'd9, 32'd3, 0, 0, lat, res);
    check("t3_result", res, 32'd3);
    check("t3_latency_after_drain", W'(lat), 32'd7);
    check("t3_sdiv_tvalid_cycles", W'(s_tv_cnt), 32'd2);

    // flush in ISSUE while tready low
    u_tv_cnt = 0; lat_u = 3; tready_mode = 2;
    fork
      run_op(2'b10, 32'd50, 32'd5, 1, 0, lat, res);
      begin repeat (4) @(negedge clk); tready_mode = 1; end
    join
    watch_idle("t4_no_ready_go", 12);
    check("t4_udiv_tvalid_cycles", W'(u_tv_cnt), 32'd4);

    // back-to-back div.wu
    lat_u = 3;
    run_op(2'b10, 32'hFFFF_FFFF, 32'd16, 0, 0, lat, res);
    check("t5a_result", res, 32'h0FFF_FFFF);
    check("t5a_latency", W'(lat), 32'd5);
    run_op(2'b10, 32'd40, 32'd8, 0, 0, lat, res);
    check("t5b_result", res, 32'd5);
    check("t5b_latency", W'(lat), 32'd5);

`ifdef DIV_ZERO_FIXUP_EN
    s_tv_cnt = 0; u_tv_cnt = 0;
    run_op(2'b00, 32'd5, 32'd0, 0, 0, lat, res);
    check("t6a_result", res, 32'hFFFF_FFFF);
    check("t6a_latency", W'(lat), 32'd1);
    run_op(2'b01, 32'd5, 32'd0, 0, 0, lat, res);
    check("t6b_result", res, 32'd5);
    check("t6_no_tvalid", W'(s_tv_cnt + u_tv_cnt), 32'd0);
`endif

    // reset in WAIT; the late IP result must be ignored
    lat_s = 5;
    op_valid = 1'b1; op = 2'b00; src1 = 32'd81; src2 = 32'd9; cur_uns = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    watch_idle("t7_reset_no_ready_go", 10);

    // randomized traffic with garbage on the idle IP and random flushes
    garbage_en = 1'b1; tready_mode = 0;
    for (int n = 0; n < 200; n++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin ra = $urandom; rb = $urandom; end
        1:       begin ra = $urandom; rb = W'($urandom_range(0, 9)); end
        2:       begin ra = W'($urandom_range(0, 1000)); rb = W'(-$urandom_range(1, 20)); end
        default: begin ra = W'(-$urandom_range(0, 1000)); rb = W'($urandom_range(1, 50)); end
      endcase
      if (!ro[1] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      if (ro[1]) lat_u = $urandom_range(1, 6); else lat_s = $urandom_range(1, 6);
      run_op(ro, ra, rb, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : 0,
             $urandom_range(0, 2), lat, res);
    end
    garbage_en = 1'b0;
    repeat (20) @(negedge clk);
    check("final_scoreboard_empty", W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
